// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the serial subtractor family.
package sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MIN_CNT_W = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // A single-slice configuration still needs a one-bit counter to exist.
  function automatic int sliceCntW(input int slices);
    return (clog2(slices) < MIN_CNT_W) ? MIN_CNT_W : clog2(slices);
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple subtractor built from full-subtractor bit equations.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic w_br;

  always_comb begin
    w_br = bi;
    d    = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ w_br;
      w_br = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_br);
    end
    bo = w_br;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one DIGIT-bit slice per clock, LSB first.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = sliceCntW(N);

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_aMsb;
  logic             r_bMsb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_done;

  logic [DIGIT-1:0] w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_resFull;

  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_accept = (r_state == IDLE) && start;

  digit_subtractor #(.DIGIT(DIGIT)) u_digit (
    .x  (r_a[DIGIT-1:0]),
    .y  (r_b[DIGIT-1:0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // Result slices enter at the MSB end so the LSB slice lands in place after N cycles.
  generate
    if (DIGIT < WIDTH) begin : g_shift
      logic [WIDTH-DIGIT-1:0] r_resHi;

      assign w_resFull = {w_d, r_resHi};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_resHi <= '0;
        end else if (r_state == BUSY) begin
          r_resHi <= w_resFull[WIDTH-1:DIGIT];
        end
      end
    end else begin : g_single
      assign w_resFull = w_d;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start)  w_nextState = BUSY;
      BUSY:    if (w_last) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand MSBs are kept aside because the operand registers are shifted away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_aMsb   <= 1'b0;
      r_bMsb   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_borrow <= bin;
        r_cnt    <= '0;
        r_aMsb   <= a[WIDTH-1];
        r_bMsb   <= b[WIDTH-1];
      end else if (r_state == BUSY) begin
        r_a      <= r_a >> DIGIT;
        r_b      <= r_b >> DIGIT;
        r_borrow <= w_bo;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= w_resFull;
          r_bout <= w_bo;
          r_ovf  <= (r_aMsb ^ r_bMsb) & (w_resFull[WIDTH-1] ^ r_aMsb);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == BUSY);
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: three subtractor lanes (DIGIT = 1, 4, 16) checked against a - b - bin.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        st    [3];
  logic [15:0] opA   [3];
  logic [15:0] opB   [3];
  logic        bi    [3];
  logic        busyW [3];
  logic        doneW [3];
  logic [15:0] diffW [3];
  logic        boutW [3];
  logic        ovfW  [3];

  int unsigned cycle   = 0;
  int          nAsserts = 0;
  int          nFails   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic bw, input int unsigned due);
    exp_t        e;
    logic [16:0] r;
    r      = {1'b0, x} - {1'b0, y} - {16'd0, bw};
    e.diff = r[15:0];
    e.bout = r[16];
    e.ovf  = (x[15] != y[15]) && (r[15] != x[15]);
    e.due  = due;
    return e;
  endfunction

  function automatic int slices(input int idx);
    return (idx == 0) ? 16 : (idx == 1) ? 4 : 1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : 16;

    exp_t        q[$];
    int unsigned doneCount = 0;

    serial_subtractor #(.WIDTH(16), .DIGIT(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (st[g]),
      .a     (opA[g]),
      .b     (opB[g]),
      .bin   (bi[g]),
      .busy  (busyW[g]),
      .done  (doneW[g]),
      .diff  (diffW[g]),
      .bout  (boutW[g]),
      .ovf   (ovfW[g])
    );

    // Each done pulse retires the oldest expected result of this lane.
    always @(posedge clk) begin
      exp_t e;
      #1;
      if (doneW[g] === 1'b1) begin
        doneCount++;
        checkVal($sformatf("lane%0d_done_expected", g), 32'(q.size() > 0), 32'd1);
        checkVal($sformatf("lane%0d_busy_with_done", g), 32'(busyW[g]), 32'd0);
        if (q.size() > 0) begin
          e = q.pop_front();
          checkVal($sformatf("lane%0d_diff", g), 32'(diffW[g]), 32'(e.diff));
          checkVal($sformatf("lane%0d_bout", g), 32'(boutW[g]), 32'(e.bout));
          checkVal($sformatf("lane%0d_ovf", g), 32'(ovfW[g]), 32'(e.ovf));
          checkVal($sformatf("lane%0d_latency", g), cycle, e.due);
        end
      end
    end
  end

  function automatic int qSize(input int idx);
    case (idx)
      0:       return lane[0].q.size();
      1:       return lane[1].q.size();
      default: return lane[2].q.size();
    endcase
  endfunction

  task automatic pushExp(input int idx, input exp_t e);
    case (idx)
      0:       lane[0].q.push_back(e);
      1:       lane[1].q.push_back(e);
      default: lane[2].q.push_back(e);
    endcase
  endtask

  task automatic applyStimulus(input int idx, input logic [15:0] x, input logic [15:0] y, input logic bw);
    opA[idx] = x;
    opB[idx] = y;
    bi[idx]  = bw;
    st[idx]  = 1'b1;
    pushExp(idx, model(x, y, bw, cycle + 1 + slices(idx)));
    @(negedge clk);
    st[idx] = 1'b0;
  endtask

  task automatic waitIdle(input int idx);
    int t;
    t = 0;
    while (qSize(idx) != 0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    checkVal($sformatf("lane%0d_drain", idx), 32'(qSize(idx)), 32'd0);
    @(negedge clk);
  endtask

  task automatic runOp(input int idx, input logic [15:0] x, input logic [15:0] y, input logic bw);
    applyStimulus(idx, x, y, bw);
    waitIdle(idx);
  endtask

  task automatic checkOutput(input string tag, input int idx);
    checkVal({tag, "_busy"}, 32'(busyW[idx]), 32'd0);
    checkVal({tag, "_done"}, 32'(doneW[idx]), 32'd0);
    checkVal({tag, "_diff"}, 32'(diffW[idx]), 32'd0);
    checkVal({tag, "_bout"}, 32'(boutW[idx]), 32'd0);
    checkVal({tag, "_ovf"},  32'(ovfW[idx]),  32'd0);
  endtask

  initial begin
    int          busyCycles;
    int unsigned prevDone;
    logic [15:0] heldA [3];
    logic [15:0] heldB [3];
    logic        heldBi[3];

    heldA  = '{16'h1111, 16'h2000, 16'h8000};
    heldB  = '{16'h0001, 16'h3000, 16'h7FFF};
    heldBi = '{1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i]  = 1'b0;
      opA[i] = '0;
      opB[i] = '0;
      bi[i]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("reset_lane%0d", i), i);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic operation with busy-length and done-width checks.
    applyStimulus(1, 16'h0005, 16'h0003, 1'b0);
    busyCycles = 0;
    for (int t = 0; t < 30; t++) begin
      if (doneW[1] === 1'b1) break;
      if (busyW[1] === 1'b1) busyCycles++;
      @(negedge clk);
    end
    checkVal("basic_busy_cycles", 32'(busyCycles), 32'd4);
    @(negedge clk);
    checkVal("basic_done_width", 32'(doneW[1]), 32'd0);
    waitIdle(1);

    runOp(1, 16'h0000, 16'h0001, 1'b0);
    runOp(1, 16'h0010, 16'h0000, 1'b1);
    runOp(1, 16'h8000, 16'h0001, 1'b0);
    runOp(1, 16'h7FFF, 16'hFFFF, 1'b0);

    // Start and operand changes during BUSY must not disturb the running operation.
    applyStimulus(1, 16'h1234, 16'h0234, 1'b0);
    opA[1] = 16'hFFFF;
    opB[1] = 16'h0001;
    bi[1]  = 1'b1;
    st[1]  = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    waitIdle(1);
    prevDone = lane[1].doneCount;
    repeat (8) @(negedge clk);
    checkVal("midbusy_no_extra_done", lane[1].doneCount, prevDone);

    // Start held high: one result every N+1 cycles with fresh operands.
    opA[1] = heldA[0];
    opB[1] = heldB[0];
    bi[1]  = heldBi[0];
    st[1]  = 1'b1;
    pushExp(1, model(heldA[0], heldB[0], heldBi[0], cycle + 1 + 4));
    @(negedge clk);
    for (int i = 1; i < 3; i++) begin
      opA[1] = heldA[i];
      opB[1] = heldB[i];
      bi[1]  = heldBi[i];
      pushExp(1, model(heldA[i], heldB[i], heldBi[i], cycle + 5 + 4));
      repeat (5) @(negedge clk);
    end
    st[1] = 1'b0;
    waitIdle(1);

    // Reset in the second BUSY cycle aborts without a done pulse.
    applyStimulus(1, 16'hABCD, 16'h1234, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort", 1);
    lane[1].q.delete();
    prevDone = lane[1].doneCount;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkVal("abort_no_done", lane[1].doneCount, prevDone);
    runOp(1, 16'h0100, 16'h0001, 1'b0);

    // Sweep over all three slice widths, including the extreme operands.
    for (int i = 0; i < 3; i++) begin
      runOp(i, 16'h0000, 16'hFFFF, 1'b1);
      runOp(i, 16'hFFFF, 16'h0000, 1'b1);
      for (int k = 0; k < 6; k++) begin
        runOp(i, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
